// File: rtl/stopwatch_core.sv
// Stopwatch core: BCD mm:ss.cc counter with run/pause/lap control driven by
// single-cycle button requests and a 100 Hz count enable.
module stopwatch_core #(
    parameter int MAX_MIN = 59
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_100hz,
    input  logic        btn_ss,
    input  logic        btn_lap,
    input  logic        btn_clr,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

    // Digit order, low to high: cs_u, cs_t, sec_u, sec_t, min_u, min_t
    localparam logic [5:0][3:0] DIGIT_LIM = {4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
    localparam logic [3:0] MAX_MIN_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MIN_U = 4'(MAX_MIN % 10);
    localparam logic [5:0][3:0] MAX_COUNT = {MAX_MIN_T, MAX_MIN_U, 4'd5, 4'd9, 4'd9, 4'd9};

    state_t           state_reg, state_next;
    logic [5:0][3:0]  count_reg, count_next, count_inc;
    logic [5:0][3:0]  lap_reg, lap_next;
    logic             overflow_reg, overflow_next;
    logic [23:0]      disp_reg;
    logic             running_reg, lap_active_reg;
    logic [6:0]       carry;

    assign carry[0] = 1'b1;

    // Ripple BCD increment; each digit rolls to zero and carries at its limit
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            logic at_lim;
            assign at_lim        = (count_reg[gi] == DIGIT_LIM[gi]);
            assign carry[gi+1]   = carry[gi] & at_lim;
            assign count_inc[gi] = !carry[gi] ? count_reg[gi] :
                                   (at_lim ? 4'd0 : count_reg[gi] + 4'd1);
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        lap_next      = lap_reg;
        overflow_next = overflow_reg;
        if (btn_clr) begin
            state_next    = IDLE;
            count_next    = '0;
            lap_next      = '0;
            overflow_next = 1'b0;
        end else begin
            // Tick is judged against the state before any transition this cycle
            if (tick_100hz && (state_reg == RUN || state_reg == LAP)) begin
                if (count_reg == MAX_COUNT) begin
                    count_next    = '0;
                    overflow_next = 1'b1;
                end else begin
                    count_next = count_inc;
                end
            end
            if (btn_ss) begin
                case (state_reg)
                    IDLE:    state_next = RUN;
                    RUN:     state_next = PAUSE;
                    PAUSE:   state_next = RUN;
                    LAP:     state_next = PAUSE;
                    default: state_next = IDLE;
                endcase
            end else if (btn_lap) begin
                case (state_reg)
                    RUN: begin
                        state_next = LAP;
                        lap_next   = count_reg;
                    end
                    LAP:     state_next = RUN;
                    PAUSE: begin
                        state_next    = IDLE;
                        count_next    = '0;
                        overflow_next = 1'b0;
                    end
                    default: state_next = state_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            lap_reg        <= '0;
            overflow_reg   <= 1'b0;
            disp_reg       <= '0;
            running_reg    <= 1'b0;
            lap_active_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            lap_reg        <= lap_next;
            overflow_reg   <= overflow_next;
            disp_reg       <= (state_reg == LAP) ? lap_reg : count_reg;
            running_reg    <= (state_reg == RUN) || (state_reg == LAP);
            lap_active_reg <= (state_reg == LAP);
        end
    end

    assign disp_bcd   = disp_reg;
    assign running    = running_reg;
    assign lap_active = lap_active_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus random button/tick traffic,
// checked against a centisecond-integer reference model.
module tb_stopwatch_core;

    localparam int MM  = 1;
    localparam int MOD = (MM + 1) * 6000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_100hz = 1'b0;
    logic        btn_ss = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clr = 1'b0;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 run, 2 pause, 3 lap; count in centiseconds
    int m_state, m_cnt, m_lap;
    bit m_ovf;
    logic [23:0] exp_disp;
    bit exp_run, exp_lapa;

    stopwatch_core #(.MAX_MIN(MM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_100hz (tick_100hz),
        .btn_ss     (btn_ss),
        .btn_lap    (btn_lap),
        .btn_clr    (btn_clr),
        .disp_bcd   (disp_bcd),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int c);
        int m, s, cs;
        m  = c / 6000;
        s  = (c / 100) % 60;
        cs = c % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_lap = 0; m_ovf = 0;
        exp_disp = '0; exp_run = 0; exp_lapa = 0;
    endtask

    task automatic model_edge(input bit c, input bit s, input bit l, input bit t);
        exp_disp = (m_state == 3) ? to_bcd(m_lap) : to_bcd(m_cnt);
        exp_run  = (m_state == 1) || (m_state == 3);
        exp_lapa = (m_state == 3);
        if (c) begin
            m_state = 0; m_cnt = 0; m_lap = 0; m_ovf = 0;
        end else begin
            int pre;
            pre = m_cnt;
            if (t && (m_state == 1 || m_state == 3)) begin
                m_cnt = (m_cnt + 1) % MOD;
                if (m_cnt == 0) m_ovf = 1;
            end
            if (s) begin
                m_state = (m_state == 1 || m_state == 3) ? 2 : 1;
            end else if (l) begin
                if (m_state == 1) begin
                    m_state = 3;
                    m_lap   = pre;
                end else if (m_state == 3) begin
                    m_state = 1;
                end else if (m_state == 2) begin
                    m_state = 0; m_cnt = 0; m_ovf = 0;
                end
            end
        end
    endtask

    // Called at a negedge: drive, clock, update model, check at next negedge
    task automatic step(input bit c, input bit s, input bit l, input bit t);
        btn_clr = c; btn_ss = s; btn_lap = l; tick_100hz = t;
        @(posedge clk);
        model_edge(c, s, l, t);
        @(negedge clk);
        btn_clr = 0; btn_ss = 0; btn_lap = 0; tick_100hz = 0;
        chk("disp", 32'(disp_bcd), 32'(exp_disp));
        chk("running", 32'(running), 32'(exp_run));
        chk("lap_active", 32'(lap_active), 32'(exp_lapa));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_disp", 32'(disp_bcd), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic count
        step(0, 1, 0, 0);
        tick_n(150);
        step(0, 0, 0, 0);
        chk("basic_disp", 32'(disp_bcd), 32'h000150);
        chk("basic_running", 32'(running), 32'h1);
        $display("scenario basic count disp=%h", disp_bcd);

        // Minute carry and wrap past MAX_MIN:59.99
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        tick_n(5999);
        step(0, 0, 0, 0);
        chk("pre_min_disp", 32'(disp_bcd), 32'h005999);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("min_carry_disp", 32'(disp_bcd), 32'h010000);
        tick_n(5999);
        step(0, 0, 0, 0);
        chk("pre_wrap_disp", 32'(disp_bcd), 32'h015999);
        chk("pre_wrap_ovf", 32'(overflow), 32'h0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("wrap_disp", 32'(disp_bcd), 32'h000000);
        chk("wrap_ovf", 32'(overflow), 32'h1);
        $display("scenario wrap disp=%h overflow=%b", disp_bcd, overflow);

        // Lap freeze and release
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        tick_n(237);
        step(0, 0, 1, 0);
        tick_n(50);
        step(0, 0, 0, 0);
        chk("lap_hold_disp", 32'(disp_bcd), 32'h000237);
        chk("lap_hold_active", 32'(lap_active), 32'h1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("lap_release_disp", 32'(disp_bcd), 32'h000287);
        chk("lap_release_active", 32'(lap_active), 32'h0);
        $display("scenario lap disp=%h", disp_bcd);

        // Pause with coincident tick, then reset-when-paused
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        tick_n(10);
        step(0, 1, 0, 1);
        tick_n(5);
        step(0, 0, 0, 0);
        chk("pause_disp", 32'(disp_bcd), 32'h000011);
        chk("pause_running", 32'(running), 32'h0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("pause_lap_disp", 32'(disp_bcd), 32'h000000);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("idle_restart_running", 32'(running), 32'h1);
        $display("scenario pause disp=%h", disp_bcd);

        // Clear beats start/stop and tick
        step(0, 0, 0, 0);
        tick_n(20);
        step(1, 1, 0, 1);
        step(0, 0, 0, 0);
        chk("clr_disp", 32'(disp_bcd), 32'h000000);
        chk("clr_running", 32'(running), 32'h0);
        chk("clr_ovf", 32'(overflow), 32'h0);
        $display("scenario clear disp=%h", disp_bcd);

        // Asynchronous reset mid-count
        step(0, 1, 0, 0);
        tick_n(742);
        step(0, 0, 0, 0);
        chk("arst_pre_disp", 32'(disp_bcd), 32'h000742);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_disp", 32'(disp_bcd), 32'h0);
        chk("arst_running", 32'(running), 32'h0);
        chk("arst_lap", 32'(lap_active), 32'h0);
        chk("arst_ovf", 32'(overflow), 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("arst_first_cycle_running", 32'(running), 32'h1);
        $display("scenario async reset disp=%h", disp_bcd);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
        end
        $display("scenario random done disp=%h", disp_bcd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter MAX_MIN, default 59: highest minutes value before wrap; legal range 1..99.
REQ-002 clk  in  1  system clock, 100 MHz; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk.
REQ-004 tick_100hz  in  1  one-clk-wide 100 Hz count enable from the clock divider (0.01 s).
REQ-005 btn_ss  in  1  start/stop request, one-clk pulse, already debounced.
REQ-006 btn_lap  in  1  lap / reset-when-paused request, one-clk pulse.
REQ-007 btn_clr  in  1  unconditional clear request, one-clk pulse.
REQ-008 disp_bcd  out  24  displayed time, {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4-bit BCD each.
REQ-009 running  out  1  high in RUN or LAP.
REQ-010 lap_active  out  1  high in LAP (display frozen).
REQ-011 overflow  out  1  sticky; set when the count wraps past MAX_MIN:59.99.

Function
REQ-012 States SHALL be IDLE, RUN, PAUSE and LAP, held in a registered state variable.
REQ-013 The live count SHALL increment by 0.01 s on every clk where tick_100hz=1 and the current (registered) state is RUN or LAP; it SHALL hold otherwise.
REQ-014 Increment SHALL use BCD carry: cs_u 9->0 carries to cs_t; cs_t 9->0 to sec_u; sec_u 9->0 to sec_t; sec_t 5->0 to min_u; min_u 9->0 to min_t.
REQ-015 At MAX_MIN:59.99 an increment SHALL wrap the count to 00:00.00 and set overflow the same edge; counting SHALL continue.
REQ-016 Request priority in one cycle SHALL be btn_clr > btn_ss > btn_lap; lower-priority requests in that cycle are discarded.
REQ-017 btn_clr in any state SHALL, on that edge, go to IDLE, zero count and lap latch, clear overflow; a simultaneous tick is discarded.
REQ-018 IDLE: btn_ss -> RUN; btn_lap ignored.
REQ-019 RUN: btn_ss -> PAUSE; btn_lap -> LAP and latches the pre-increment live count into the lap register.
REQ-020 LAP: btn_lap -> RUN (display returns to live); btn_ss -> PAUSE (display returns to live).
REQ-021 PAUSE: btn_ss -> RUN; btn_lap -> IDLE with count zeroed and overflow cleared.
REQ-022 A tick coincident with a transition SHALL be evaluated against the pre-transition state (tick with btn_ss in RUN counts; tick with btn_ss in IDLE or PAUSE does not).
REQ-023 disp_bcd SHALL be registered: lap register in LAP, otherwise live count; it reflects an increment or transition one clk after the causing edge.
REQ-024 running and lap_active SHALL be registered decodes of the state, aligned with disp_bcd.
REQ-025 Digits SHALL never hold a non-BCD value or sec_t>5.

Reset
REQ-026 While rst_n=0: state IDLE, count and lap register 00:00.00, disp_bcd=24'h000000, running=0, lap_active=0, overflow=0.
REQ-027 Assertion of rst_n mid-count SHALL take effect immediately without waiting for clk; inputs during the first clk after deassertion SHALL be processed normally.

Verification
REQ-028 Reset, btn_ss, 150 ticks -> disp_bcd=24'h000150 (00:01.50), running=1.
REQ-029 Preload 00:59.99 in RUN, one tick -> 24'h010000; preload MAX_MIN:59.99 (24'h595999), one tick -> 24'h000000, overflow=1.
REQ-030 RUN at 00:02.37, btn_lap then 50 ticks -> disp holds 24'h000237, lap_active=1; btn_lap -> disp 24'h000287.
REQ-031 RUN, btn_ss with tick same cycle -> count +1, state PAUSE; further ticks -> no change; btn_lap -> 24'h000000, IDLE.
REQ-032 btn_clr+btn_ss+tick same cycle in RUN -> IDLE, 24'h000000, running=0, overflow=0.
REQ-033 rst_n pulsed low between clk edges at 00:07.42 -> all outputs zero before next edge.
